// File: rtl/fetch_pkg.sv
//============================================================================
// Module  : fetch_pkg
// Brief   : Shared types and defaults for the instruction fetch unit and the
//           3-bit-opcode control decoder (state encoding, field widths,
//           opcode field extraction).
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

package fetch_pkg;

    localparam int FETCH_PC_W    = 10;
    localparam int FETCH_INSTR_W = 9;
    localparam int FETCH_OP_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

    // Opcode lives in the top OP_W bits of the instruction word; the decoder
    // uses the same helper so both sides agree on the field position.
    function automatic logic [FETCH_OP_W-1:0] opcode_field(
        input logic [FETCH_INSTR_W-1:0] instr_word
    );
        return instr_word[FETCH_INSTR_W-1 -: FETCH_OP_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_lut.sv
//============================================================================
// Module  : branch_lut
// Brief   : Combinational branch-target table. 2**LUT_W absolute PC targets,
//           contents supplied as a packed vector (entry i at bits
//           [i*PC_W +: PC_W]) generated from the branch-target hex file.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module branch_lut #(
    parameter int                             PC_W     = 10,
    parameter int                             LUT_W    = 5,
    parameter logic [(2**LUT_W)*PC_W-1:0]     LUT_INIT = '0
) (
    input  logic [LUT_W-1:0] i_idx,
    output logic [PC_W-1:0]  o_target
);

    localparam int DEPTH = 2**LUT_W;

    logic [PC_W-1:0] w_entries [DEPTH];

    // Unpack the flat initialisation vector into addressable entries.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign w_entries[i] = LUT_INIT[i*PC_W +: PC_W];
    end

    assign o_target = w_entries[i_idx];

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
//============================================================================
// Module  : instr_fetch
// Brief   : Instruction sequencer. Owns the PC, addresses a synchronous
//           instruction ROM with the next PC so data lines up with pc, and
//           presents one instruction per cycle. Handles stall, halt, taken
//           branches via a target LUT, start/done run control and a
//           saturating run-cycle counter.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                             PC_W     = FETCH_PC_W,
    parameter int                             INSTR_W  = FETCH_INSTR_W,
    parameter int                             OP_W     = FETCH_OP_W,
    parameter int                             LUT_W    = 5,
    parameter int                             CNT_W    = 16,
    parameter logic [(2**LUT_W)*PC_W-1:0]     LUT_INIT = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               halt,
    input  logic               branch_taken,
    input  logic [LUT_W-1:0]   branch_idx,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [OP_W-1:0]    opcode,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               done,
    output logic [CNT_W-1:0]   cycle_cnt
);

    localparam logic [PC_W-1:0]  C_PC_LAST = '1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  w_br_target;
    logic             w_running;

    branch_lut #(
        .PC_W     (PC_W),
        .LUT_W    (LUT_W),
        .LUT_INIT (LUT_INIT)
    ) u_branch_lut (
        .i_idx    (branch_idx),
        .o_target (w_br_target)
    );

    // Next state, next PC and next cycle count. pc_d doubles as the ROM
    // address so the word read this cycle belongs to next cycle's pc.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (start) begin
                    state_d = PRIME;
                    cnt_d   = '0;
                end
            end
            PRIME: begin
                pc_d    = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (cnt_q != C_CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Halt beats stall beats branch; a stall re-reads pc so the
                // decoder can re-present the branch once the stall clears.
                if (halt) begin
                    state_d = DONE;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (branch_taken) begin
                    pc_d = w_br_target;
                end else if (pc_q == C_PC_LAST) begin
                    state_d = DONE;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = PRIME;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, PC and counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign w_running   = (state_q == RUN);
    assign imem_addr   = pc_d;
    assign instr       = w_running ? imem_rdata : '0;
    assign instr_valid = w_running;
    assign pc          = pc_q;
    assign done        = (state_q == DONE);
    assign cycle_cnt   = cnt_q;

    if (INSTR_W == FETCH_INSTR_W && OP_W == FETCH_OP_W) begin : g_op_pkg
        assign opcode = opcode_field(instr);
    end else begin : g_op_slice
        assign opcode = instr[INSTR_W-1 -: OP_W];
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//============================================================================
// Module  : tb_instr_fetch
// Brief   : Scoreboard bench for instr_fetch. Stimulus pushes the expected
//           pc/instr/opcode/count for every RUN cycle; a negedge monitor pops
//           and compares whenever instr_valid is high. A second instance with
//           a 4-bit counter shares the stimulus to exercise saturation.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instr_fetch;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int OP_W    = 3;
    localparam int LUT_W   = 5;
    localparam int DEPTH   = 32;

    function automatic logic [PC_W-1:0] lut_val(input int i);
        case (i)
            3:       return 10'd100;
            4:       return 10'd7;
            5:       return 10'd9;
            7:       return 10'd1023;
            8:       return 10'd37;
            default: return PC_W'(i * 3 + 1);
        endcase
    endfunction

    function automatic logic [DEPTH*PC_W-1:0] mk_lut();
        logic [DEPTH*PC_W-1:0] v;
        v = '0;
        for (int i = 0; i < DEPTH; i++) v[i*PC_W +: PC_W] = lut_val(i);
        return v;
    endfunction

    localparam logic [DEPTH*PC_W-1:0] LUT_INIT = mk_lut();

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [OP_W-1:0]    op;
        logic [15:0]        cnt;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n, start, stall, halt, branch_taken;
    logic [LUT_W-1:0]   branch_idx;
    logic [PC_W-1:0]    addr_a, pc_a, addr_b, pc_b;
    logic [INSTR_W-1:0] rdata_a, instr_a, rdata_b, instr_b;
    logic [OP_W-1:0]    opcode_a, opcode_b;
    logic               valid_a, done_a, valid_b, done_b;
    logic [15:0]        cnt_a;
    logic [3:0]         cnt_b;

    logic [INSTR_W-1:0] rom [1024];
    exp_t               sb_q[$];
    exp_t               mon_e;
    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [PC_W-1:0]    exp_pc;
    int                 exp_cnt;

    instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .OP_W(OP_W), .LUT_W(LUT_W),
                  .CNT_W(16), .LUT_INIT(LUT_INIT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
        .branch_taken(branch_taken), .branch_idx(branch_idx),
        .imem_addr(addr_a), .imem_rdata(rdata_a), .instr(instr_a),
        .opcode(opcode_a), .instr_valid(valid_a), .pc(pc_a), .done(done_a),
        .cycle_cnt(cnt_a)
    );

    instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .OP_W(OP_W), .LUT_W(LUT_W),
                  .CNT_W(4), .LUT_INIT(LUT_INIT)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
        .branch_taken(branch_taken), .branch_idx(branch_idx),
        .imem_addr(addr_b), .imem_rdata(rdata_b), .instr(instr_b),
        .opcode(opcode_b), .instr_valid(valid_b), .pc(pc_b), .done(done_b),
        .cycle_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model, one-cycle read latency.
    always @(posedge clk) begin
        rdata_a <= rom[addr_a];
        rdata_b <= rom[addr_b];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid instruction must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && valid_a) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: pc %0d presented, none expected", pc_a);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pc",        32'(pc_a),     32'(mon_e.pc));
                chk("instr",     32'(instr_a),  32'(mon_e.instr));
                chk("opcode",    32'(opcode_a), 32'(mon_e.op));
                chk("cycle_cnt", 32'(cnt_a),    32'(mon_e.cnt));
                chk("cnt4_sat",  32'(cnt_b),    (mon_e.cnt > 16'd15) ? 32'd15 : 32'(mon_e.cnt));
                chk("valid4",    32'(valid_b),  32'd1);
            end
        end
    end

    // One RUN cycle: apply controls, record the expected view of this cycle,
    // then advance the expected PC by the sequencing rules.
    task automatic step(input bit s, input bit h, input bit b, input int idx);
        exp_t e;
        stall        = s;
        halt         = h;
        branch_taken = b;
        branch_idx   = LUT_W'(idx);
        e.pc    = exp_pc;
        e.instr = rom[exp_pc];
        e.op    = rom[exp_pc][INSTR_W-1 -: OP_W];
        e.cnt   = 16'(exp_cnt);
        sb_q.push_back(e);
        exp_cnt++;
        if (h)                    exp_pc = exp_pc;
        else if (s)               exp_pc = exp_pc;
        else if (b)               exp_pc = lut_val(idx);
        else if (exp_pc != 10'd1023) exp_pc = exp_pc + 10'd1;
        @(posedge clk);
        #1;
        stall        = 1'b0;
        halt         = 1'b0;
        branch_taken = 1'b0;
        branch_idx   = '0;
    endtask

    // Issue start from IDLE/DONE, check the PRIME cycle, land in first RUN cycle.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("prime_valid", 32'(valid_a), 32'd0);
        chk("prime_pc",    32'(pc_a),    32'd0);
        chk("prime_cnt",   32'(cnt_a),   32'd0);
        chk("prime_done",  32'(done_a),  32'd0);
        @(posedge clk);
        #1;
        exp_pc  = '0;
        exp_cnt = 0;
    endtask

    task automatic chk_done(input int epc, input int ecnt);
        chk("done_flag",  32'(done_a),  32'd1);
        chk("done_valid", 32'(valid_a), 32'd0);
        chk("done_pc",    32'(pc_a),    32'(epc));
        chk("done_cnt",   32'(cnt_a),   32'(ecnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'((i * 13 + 5) & 511);
        rom[0] = 9'h040;
        rom[1] = 9'h081;
        rom[2] = 9'h0C2;
        rom[3] = 9'h103;
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0;
        branch_taken = 1'b0; branch_idx = '0;
        exp_pc = '0; exp_cnt = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_done",  32'(done_a),  32'd0);
        chk("rst_pc",    32'(pc_a),    32'd0);
        chk("rst_cnt",   32'(cnt_a),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_addr",  32'(addr_a),  32'd0);
        chk("idle_valid", 32'(valid_a), 32'd0);

        // Run 1: sequential opcodes, branch, branch back, stall+branch, halt.
        do_start();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);  // pc 0..4
        step(0, 0, 1, 3);                              // pc 5 -> 100
        step(0, 0, 1, 4);                              // pc 100 -> 7
        repeat (3) step(1, 0, 1, 5);                   // pc 7 stalled
        step(0, 0, 1, 5);                              // pc 7 -> 9
        step(0, 1, 0, 0);                              // pc 9 halt
        chk_done(9, 12);

        // Run 2: straight to pc 20, halt together with a branch.
        do_start();
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
        step(0, 1, 1, 3);
        chk_done(20, 21);
        chk("cnt4_after_halt", 32'(cnt_b), 32'd15);
        repeat (2) @(posedge clk);
        #1;
        chk_done(20, 21);

        // Run 3: branch to last ROM word, must finish without wrapping.
        do_start();
        step(0, 0, 1, 7);                              // pc 0 -> 1023
        step(0, 0, 0, 0);                              // pc 1023 -> DONE
        chk_done(1023, 2);
        repeat (3) @(posedge clk);
        #1;
        chk_done(1023, 2);

        // Run 4: asynchronous reset while running at pc 37.
        do_start();
        step(0, 0, 1, 8);                              // pc 0 -> 37
        chk("pre_rst_pc",    32'(pc_a),    32'd37);
        chk("pre_rst_valid", 32'(valid_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc",    32'(pc_a),    32'd0);
        chk("mid_rst_valid", 32'(valid_a), 32'd0);
        chk("mid_rst_done",  32'(done_a),  32'd0);
        chk("mid_rst_cnt",   32'(cnt_a),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_start();
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk_done(1, 2);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
